// File: rtl/alu_fpga_seq.sv
// Board harness around an external ALU: synchronised push-button commits load
// operands/opcode, a three-state execute FSM captures the ALU result, and a
// paged, source-selectable seven-segment display shows A, B or the result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting; commits load A/B/opcode or start an execute
// S_EXEC    | operands held stable while the external ALU settles
// S_CAPTURE | result and flags latched from the ALU this cycle
module alu_fpga_seq #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 15,
  parameter int OP_W   = 4,
  parameter int NHEX   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          KEY,
  input  logic [17:0]         SW,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_neg,
  input  logic                alu_ovf,
  input  logic                alu_zero,
  output logic [17:0]         LEDR,
  output logic [7*NHEX-1:0]   HEX
);

  localparam int NIB    = DATA_W / 4;
  localparam int NPAGES = (DATA_W + 4 * NHEX - 1) / (4 * NHEX);
  localparam int PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int FILL_W = DATA_W - SW_W;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          key_s1, key_s2, key_prev, press;
  logic [DATA_W-1:0]   result;
  logic [2:0]          flags;     // {ovf, neg, zero}
  logic [PAGE_W-1:0]   page;
  logic [1:0]          disp_src;  // 0 result, 1 A, 2 B
  logic                idle, busy, capture;
  logic [1:0]          mode;
  logic [DATA_W-1:0]   sw_fill;
  logic [DATA_W-1:0]   src_val;
  logic [7*NHEX-1:0]   hex_d;
  logic [3:0]          page_led;
  int                  page_base;
  logic                unused_key3;

  assign press       = key_prev & ~key_s2;
  assign mode        = SW[17:16];
  assign sw_fill     = {{FILL_W{SW[15]}}, SW[SW_W-1:0]};
  assign idle        = (state_q == S_IDLE);
  assign busy        = ~idle;
  assign page_led    = 4'(page);
  assign page_base   = int'(page) * NHEX;
  assign unused_key3 = press[3];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] v, input int idx);
    logic [DATA_W-1:0] sh;
    sh = v >> (4 * idx);
    return sh[3:0];
  endfunction

  // Two-flop synchroniser plus previous-value flop; reset to "released" so no press escapes reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_s1   <= '1;
      key_s2   <= '1;
      key_prev <= '1;
    end else begin
      key_s1   <= KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; commits outside IDLE fall through unused
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE:    if (press[0] && mode == 2'b11) state_d = S_EXEC;
      S_EXEC:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand/opcode loads and result capture; loads only while idle so the ALU inputs stay put
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (press[0] && idle) begin
        case (mode)
          2'b00:   alu_a  <= sw_fill;
          2'b01:   alu_b  <= sw_fill;
          2'b10:   alu_op <= SW[OP_W-1:0];
          default: ;
        endcase
      end
      if (capture) begin
        result <= alu_out;
        flags  <= {alu_ovf, alu_neg, alu_zero};
      end
    end
  end

  // Page and display-source selection, honoured in every FSM state
  always_ff @(posedge CLK) begin
    if (RST) begin
      page     <= '0;
      disp_src <= 2'd0;
    end else begin
      if (press[1]) begin
        if (page == PAGE_W'(NPAGES - 1)) page <= '0;
        else                             page <= page + PAGE_W'(1);
      end
      if (press[2]) begin
        if (disp_src == 2'd2) disp_src <= 2'd0;
        else                  disp_src <= disp_src + 2'd1;
      end
    end
  end

  // Display source mux
  always_comb begin
    unique case (disp_src)
      2'd1:    src_val = alu_a;
      2'd2:    src_val = alu_b;
      default: src_val = result;
    endcase
  end

  // Per-digit nibble decode; digits past the top nibble stay blank
  always_comb begin
    hex_d = '1;
    for (int d = 0; d < NHEX; d++) begin
      if (page_base + d < NIB) hex_d[7*d +: 7] = seg7(nib_at(src_val, page_base + d));
    end
  end

  // Registered board outputs
  always_ff @(posedge CLK) begin
    HEX  <= hex_d;
    LEDR <= {8'd0, page_led, disp_src, busy, flags[0], flags[2], flags[1]};
  end

endmodule

// File: tb/tb_alu_fpga_seq.sv
// Directed bench for alu_fpga_seq: three instances (32/64/40-bit) share the
// board inputs; a small ALU model per instance stands in for the external alu.
module tb_alu_fpga_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  KEY;
  logic [17:0] SW;

  logic [31:0] a32, b32, o32;
  logic [63:0] a64, b64, o64;
  logic [39:0] a40, b40, o40;
  logic [3:0]  op32, op64, op40;
  logic        n32, v32, z32, n64, v64, z64, n40, v40, z40;
  logic [17:0] led32, led64, led40;
  logic [55:0] hex32, hex64, hex40;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  localparam logic [6:0] S0 = 7'b1000000, S3 = 7'b0110000, S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000, SF = 7'b0001110, BL = 7'h7F;
  localparam logic [55:0] H_ZERO = {8{S0}};
  localparam logic [55:0] H_F    = {8{SF}};
  localparam logic [55:0] H_8    = {{7{S0}}, S8};
  localparam logic [55:0] H_5    = {{7{S0}}, S5};
  localparam logic [55:0] H_3    = {{7{S0}}, S3};
  localparam logic [55:0] H_F40  = {{6{BL}}, {2{SF}}};

  always #5 CLK = ~CLK;

  // Reference ALU: op 2 add, op 3 subtract, otherwise AND
  assign o32 = (op32 == 4'd2) ? a32 + b32 : (op32 == 4'd3) ? a32 - b32 : a32 & b32;
  assign n32 = o32[31];
  assign z32 = (o32 == '0);
  assign v32 = (op32 == 4'd2) ? (a32[31] == b32[31]) && (o32[31] != a32[31]) :
               (op32 == 4'd3) ? (a32[31] != b32[31]) && (o32[31] != a32[31]) : 1'b0;
  assign o64 = (op64 == 4'd2) ? a64 + b64 : (op64 == 4'd3) ? a64 - b64 : a64 & b64;
  assign n64 = o64[63];
  assign z64 = (o64 == '0);
  assign v64 = (op64 == 4'd2) ? (a64[63] == b64[63]) && (o64[63] != a64[63]) :
               (op64 == 4'd3) ? (a64[63] != b64[63]) && (o64[63] != a64[63]) : 1'b0;
  assign o40 = (op40 == 4'd2) ? a40 + b40 : (op40 == 4'd3) ? a40 - b40 : a40 & b40;
  assign n40 = o40[39];
  assign z40 = (o40 == '0);
  assign v40 = (op40 == 4'd2) ? (a40[39] == b40[39]) && (o40[39] != a40[39]) :
               (op40 == 4'd3) ? (a40[39] != b40[39]) && (o40[39] != a40[39]) : 1'b0;

  alu_fpga_seq u32 (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW),
    .alu_a(a32), .alu_b(b32), .alu_op(op32), .alu_out(o32),
    .alu_neg(n32), .alu_ovf(v32), .alu_zero(z32), .LEDR(led32), .HEX(hex32)
  );

  alu_fpga_seq #(.DATA_W(64)) u64 (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW),
    .alu_a(a64), .alu_b(b64), .alu_op(op64), .alu_out(o64),
    .alu_neg(n64), .alu_ovf(v64), .alu_zero(z64), .LEDR(led64), .HEX(hex64)
  );

  alu_fpga_seq #(.DATA_W(40)) u40 (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW),
    .alu_a(a40), .alu_b(b40), .alu_op(op40), .alu_out(o40),
    .alu_neg(n40), .alu_ovf(v40), .alu_zero(z40), .LEDR(led40), .HEX(hex40)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_hold(input logic [3:0] mask);
    KEY = ~mask;
    tick(4);
    KEY = 4'hF;
    tick(4);
  endtask

  task automatic load(input logic [1:0] m, input logic s, input logic [14:0] v);
    SW = {m, s, v};
    press_hold(4'b0001);
  endtask

  initial begin
    RST = 1'b1;
    KEY = 4'hF;
    SW  = '0;
    tick(2);
    RST = 1'b0;
    chk("rst_a",     64'(a32),   64'd0);
    chk("rst_b",     64'(b32),   64'd0);
    chk("rst_op",    64'(op32),  64'd0);
    chk("rst_led",   64'(led32), 64'd0);
    chk("rst_hex32", 64'(hex32), 64'(H_ZERO));
    chk("rst_hex40", 64'(hex40), 64'(H_ZERO));
    tick(4);
    chk("rst_nopress_led", 64'(led32), 64'd0);
    chk("rst_nopress_a",   64'(a32),   64'd0);

    // A load latency: key sampled low at edge k, register written at k+2
    SW  = {2'b00, 1'b0, 15'd5};
    KEY = 4'hE;
    tick(2);
    chk("a_early", 64'(a32), 64'd0);
    tick(1);
    chk("a_k2", 64'(a32), 64'd5);
    tick(1);
    KEY = 4'hF;
    tick(4);
    SW = {2'b00, 1'b0, 15'h1234};
    tick(3);
    chk("sw_static", 64'(a32), 64'd5);

    // Sign fill, and a held key giving exactly one press
    SW  = {2'b00, 1'b1, 15'h7FFF};
    KEY = 4'hE;
    tick(4);
    chk("a_fill32", 64'(a32), 64'hFFFF_FFFF);
    chk("a_fill64", a64,      64'hFFFF_FFFF_FFFF_FFFF);
    chk("a_fill40", 64'(a40), 64'hFF_FFFF_FFFF);
    SW = {2'b00, 1'b0, 15'd9};
    tick(4);
    chk("held_once", 64'(a32), 64'hFFFF_FFFF);
    KEY = 4'hF;
    tick(4);

    load(2'b00, 1'b0, 15'd5);
    chk("a_reload", 64'(a32), 64'd5);
    load(2'b01, 1'b0, 15'd3);
    chk("b_load", 64'(b32), 64'd3);
    load(2'b10, 1'b0, 15'd2);
    chk("op_load", 64'(op32), 64'd2);

    // Full execute 5+3: busy visible for two cycles, HEX updates at k+5
    SW  = {2'b11, 1'b0, 15'd0};
    KEY = 4'hE;
    tick(3);
    chk("busy_k2", 64'(led32[3]), 64'd0);
    tick(1);
    chk("busy_k3", 64'(led32[3]), 64'd1);
    KEY = 4'hF;
    tick(1);
    chk("busy_k4", 64'(led32[3]), 64'd1);
    chk("hex_k4",  64'(hex32),    64'(H_ZERO));
    tick(1);
    chk("busy_k5", 64'(led32[3]), 64'd0);
    chk("hex_res8", 64'(hex32),   64'(H_8));
    chk("led_res8", 64'(led32),   64'd0);
    tick(4);

    // Second commit arriving mid-execute must be dropped
    KEY = 4'hE;
    tick(1);
    KEY = 4'hF;
    tick(1);
    KEY = 4'hE;
    tick(1);
    KEY = 4'hF;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (led32[3]) busy_cnt++;
    end
    chk("drop_busy_cycles", 64'(busy_cnt), 64'd2);
    chk("drop_idle", 64'(led32[3]), 64'd0);
    chk("drop_hex",  64'(hex32),    64'(H_8));

    // Display source cycling RESULT -> A -> B -> RESULT
    press_hold(4'b0100);
    chk("src_a_hex", 64'(hex32), 64'(H_5));
    chk("src_a_led", 64'(led32), 64'h10);
    press_hold(4'b0100);
    chk("src_b_hex", 64'(hex32), 64'(H_3));
    chk("src_b_led", 64'(led32), 64'h20);
    press_hold(4'b0100);
    chk("src_r_hex", 64'(hex32), 64'(H_8));
    chk("src_r_led", 64'(led32), 64'h00);

    // Paging on all-ones A
    load(2'b00, 1'b1, 15'h7FFF);
    press_hold(4'b0100);
    chk("pg0_hex32", 64'(hex32), 64'(H_F));
    chk("pg0_hex64", 64'(hex64), 64'(H_F));
    chk("pg0_led64", 64'(led64), 64'h10);
    chk("pg0_hex40", 64'(hex40), 64'(H_F));
    press_hold(4'b0010);
    chk("pg1_led32", 64'(led32), 64'h10);
    chk("pg1_hex32", 64'(hex32), 64'(H_F));
    chk("pg1_led64", 64'(led64), 64'h50);
    chk("pg1_hex64", 64'(hex64), 64'(H_F));
    chk("pg1_led40", 64'(led40), 64'h50);
    chk("pg1_blank40", 64'(hex40), 64'(H_F40));
    press_hold(4'b0010);
    chk("pgwrap_led64", 64'(led64), 64'h10);
    chk("pgwrap_hex40", 64'(hex40), 64'(H_F));

    // Page and source pressed together are both taken
    press_hold(4'b0110);
    chk("both_led64", 64'(led64), 64'h60);
    chk("both_hex64", 64'(hex64), 64'(H_ZERO));
    chk("both_led32", 64'(led32), 64'h20);
    chk("both_hex32", 64'(hex32), 64'(H_3));
    press_hold(4'b0110);
    chk("back_led64", 64'(led64), 64'h00);

    // Subtract equal operands: zero flag set
    load(2'b01, 1'b1, 15'h7FFF);
    load(2'b10, 1'b0, 15'd3);
    SW = {2'b11, 1'b0, 15'd0};
    press_hold(4'b0001);
    chk("sub_zero_led", 64'(led32), 64'h04);
    chk("sub_zero_hex", 64'(hex32), 64'(H_ZERO));

    // Reset during EXEC aborts and clears everything
    load(2'b00, 1'b0, 15'd5);
    SW  = {2'b11, 1'b0, 15'd0};
    KEY = 4'hE;
    tick(3);
    RST = 1'b1;
    KEY = 4'hF;
    tick(1);
    RST = 1'b0;
    tick(1);
    chk("abort_a",   64'(a32),   64'd0);
    chk("abort_led", 64'(led32), 64'd0);
    chk("abort_hex", 64'(hex32), 64'(H_ZERO));
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (led32[3]) busy_cnt++;
    end
    chk("abort_nobusy", 64'(busy_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_fpga_seq.md
# alu_fpga_seq

Registered, parametrised board-level harness for the ALU. Operands, opcode and results are latched on debounced push-button edges. The block replaces purely combinational switch-to-ALU wiring with synchronised key inputs, a small execute FSM and a paged, source-selectable hex display. It sits between the DE2 board pins and the `alu` module, which is instantiated outside this block.

## Interface
Parameters:
- DATA_W, 32, ALU operand and result width (multiple of 4, at least SW_W+1)
- SW_W, 15, switch bits used as operand value
- OP_W, 4, opcode width (at most SW_W)
- NHEX, 8, number of seven-segment digits driven

Ports:
- CLK  in  1  system clock; one clock domain, everything on rising edge
- RST  in  1  synchronous reset, active-high
- KEY  in  4  push buttons, active-low, asynchronous to CLK
- SW  in  18  slide switches, used level-sensitive and quasi-static
- alu_a  out  DATA_W  operand A register
- alu_b  out  DATA_W  operand B register
- alu_op  out  OP_W  opcode register
- alu_out  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_neg, alu_ovf, alu_zero  in  1 each  ALU flags
- LEDR  out  18  status LEDs
- HEX  out  7*NHEX  digit d on HEX[7d+6:7d], active-low segments

## Operation
- Key conditioning:
  - Each KEY bit passes through a 2-FF synchroniser, then a previous-value flop.
  - `press[i]` is a one-cycle pulse when the previous value is 1 and the synchronised value is 0.
- KEY[0] (commit). Action depends on SW[17:16]:
  - 00: alu_a <= {(DATA_W-SW_W){SW[15]}, SW[SW_W-1:0]}
  - 01: alu_b <= the same fill rule
  - 10: alu_op <= SW[OP_W-1:0]
  - 11: start execute
- KEY[1] (page): page <= (page+1) mod NPAGES, where NPAGES = ceil(DATA_W/(4*NHEX)). With NPAGES=1, page stays 0.
- KEY[2] (source): disp_src cycles RESULT(0) -> A(1) -> B(2) -> RESULT. Code 3 is never reached.
- KEY[3]: ignored.
- FSM states: IDLE, EXEC, CAPTURE.
  - IDLE -> EXEC on commit with mode 11.
  - EXEC -> CAPTURE unconditionally; operands are held stable so the ALU settles.
  - CAPTURE: result <= alu_out and flags <= {alu_ovf, alu_neg, alu_zero}, then -> IDLE.
  - Commits arriving in EXEC or CAPTURE are dropped. Page and source presses are always honoured.
- Display:
  - Digit d shows nibble (page*NHEX + d) of the selected source.
  - A nibble index at or beyond DATA_W/4 shows blank (7'h7F).
  - Encoding:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - c=0100111, d=0100001, E=0000110, F=0001110
  - HEX is registered.
- LEDR map:
  - [0] neg, [1] ovf, [2] zero (registered flags)
  - [3] busy (state != IDLE)
  - [5:4] disp_src
  - [9:6] page[3:0]
  - [17:10] = 0

## Timing
- Reset, at the rising edge with RST=1:
  - alu_a, alu_b, alu_op, result, flags, page and disp_src = 0
  - state = IDLE
  - synchroniser and previous-value flops = 1 (released keys), so there is no spurious press out of reset
  - Next edge: HEX = all digits 1000000 ("0"), or blank per the blank rule; LEDR = 0
- RST asserted mid-execute aborts the execute. No capture happens, and the registers clear as above.
- Key latency:
  - KEY low before edge k gives press asserted after edge k+1.
  - Target register is updated at edge k+2.
- Execute latency:
  - Commit at edge k+2 puts the FSM in EXEC.
  - result and flags are written at k+4.
  - HEX and LEDR reflect the new values at k+5.
- A held key yields exactly one press. Release followed by re-press yields another.
- Simultaneous presses on different keys in the same cycle are all processed in that cycle.
- Page wraps from NPAGES-1 to 0.
- Changing SW between commits has no effect on the registers.

## Test plan
- Reset with RST=1 for 2 cycles, keys released: every output at its reset value; HEX digits all 1000000; no press pulse after RST falls.
- Load A: SW=0x0_0005 with mode 00, SW[15]=0, pulse KEY[0] low 4 cycles -> alu_a=32'h0000_0005 exactly 2 edges after KEY is sampled low. Then with SW[15]=1 and SW[14:0]=0x7FFF -> alu_a=32'hFFFF_FFFF.
- Full execute: A=5, B=3, opcode=add code, commit with mode 11 -> LEDR[3] high for 2 cycles; result=8; HEX0=0000000; HEX1..7=1000000; zero=0.
- Dropped commit: a second mode-11 press arriving during EXEC -> exactly one CAPTURE, and the FSM returns to IDLE.
- Display source: after the execute above, press KEY[2] once -> HEX0 shows 0010010 (A=5) and LEDR[5:4]=01. Twice more -> back to RESULT.
- Paging: with DATA_W=64 and NHEX=8, load A=0xFFFF_FFFF_FFFF_FFFF via the sign fill -> page 0 all F. Press KEY[1] -> page=1, LEDR[6]=1, still all F. Press again -> page=0.
